// File: rtl/win_filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | win_filter_pkg : shared types and constants for window_filter_pipe   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package win_filter_pkg;

  typedef enum logic [1:0] {
    MODE_MEAN   = 2'b00,
    MODE_MEDIAN = 2'b01,
    MODE_BYPASS = 2'b10
  } mode_e;

  localparam int WIN_N      = 9;
  localparam int CENTER_IDX = 4;

  // Nine DATA_W-bit values sum to at most 9*(2^DATA_W-1), which fits DATA_W+4 bits.
  function automatic int sum_w(input int data_w);
    return data_w + 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_filter_pipe_sort3.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sort3_u  : combinational ascending sorter of three DATA_W values      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module sort3_u #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mid,
  output logic [DATA_W-1:0] hi
);

  logic              w_a_lt_b;
  logic [DATA_W-1:0] w_ab_lo;
  logic [DATA_W-1:0] w_ab_hi;
  logic [DATA_W-1:0] w_hi_c_min;

  assign w_a_lt_b   = (a < b);
  assign w_ab_lo    = w_a_lt_b ? a : b;
  assign w_ab_hi    = w_a_lt_b ? b : a;
  assign lo         = (w_ab_lo < c) ? w_ab_lo : c;
  assign hi         = (w_ab_hi > c) ? w_ab_hi : c;
  // mid = max(min(a,b), min(max(a,b), c))
  assign w_hi_c_min = (w_ab_hi < c) ? w_ab_hi : c;
  assign mid        = (w_ab_lo > w_hi_c_min) ? w_ab_lo : w_hi_c_min;

endmodule
`default_nettype wire

// File: rtl/window_filter_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | window_filter_pipe : 3-stage 3x3 mean / median / bypass filter       |
// | Option macro WIN_FILTER_CNT_EN adds out_count (delivered results).   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module window_filter_pipe
  import win_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROUND  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIN_N*DATA_W-1:0] in_win,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data
`ifdef WIN_FILTER_CNT_EN
  ,
  output logic [31:0]             out_count
`endif
);

  localparam int                 c_sum_w     = sum_w(DATA_W);
  localparam logic [c_sum_w-1:0] c_round_add = (ROUND != 0) ? c_sum_w'(4) : '0;
  localparam logic [c_sum_w-1:0] c_div       = c_sum_w'(9);

  logic                    w_adv;

  logic                    r_s1_valid;
  logic [WIN_N*DATA_W-1:0] r_s1_win;
  logic [1:0]              r_s1_mode;

  logic [c_sum_w-1:0]      w_sum;
  logic [2:0][DATA_W-1:0]  w_row_lo;
  logic [2:0][DATA_W-1:0]  w_row_mid;
  logic [2:0][DATA_W-1:0]  w_row_hi;

  logic                    r_s2_valid;
  logic [1:0]              r_s2_mode;
  logic [c_sum_w-1:0]      r_s2_sum;
  logic [2:0][DATA_W-1:0]  r_s2_lo;
  logic [2:0][DATA_W-1:0]  r_s2_mid;
  logic [2:0][DATA_W-1:0]  r_s2_hi;
  logic [DATA_W-1:0]       r_s2_center;

  logic [DATA_W-1:0]       w_lo_max;
  logic [DATA_W-1:0]       w_hi_min;
  logic [DATA_W-1:0]       w_mid_med;
  logic [DATA_W-1:0]       w_median;
  logic [DATA_W-1:0]       w_mean;
  logic [DATA_W-1:0]       w_result;
  logic [DATA_W-1:0]       w_unused_mid_lo;
  logic [DATA_W-1:0]       w_unused_mid_hi;
  logic [DATA_W-1:0]       w_unused_med_lo;
  logic [DATA_W-1:0]       w_unused_med_hi;

  logic                    r_out_valid;
  logic [DATA_W-1:0]       r_out_data;

  function automatic logic [DATA_W-1:0] max3(input logic [2:0][DATA_W-1:0] v);
    logic [DATA_W-1:0] m;
    m = (v[0] > v[1]) ? v[0] : v[1];
    return (m > v[2]) ? m : v[2];
  endfunction

  function automatic logic [DATA_W-1:0] min3(input logic [2:0][DATA_W-1:0] v);
    logic [DATA_W-1:0] m;
    m = (v[0] < v[1]) ? v[0] : v[1];
    return (m < v[2]) ? m : v[2];
  endfunction

  // Whole pipeline moves in lock-step, so a stalled output freezes every stage.
  assign w_adv     = !r_out_valid || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WIN_N; i++) begin
      w_sum = w_sum + c_sum_w'(r_s1_win[i*DATA_W +: DATA_W]);
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_row
    sort3_u #(.DATA_W(DATA_W)) u_sort (
      .a   (r_s1_win[(3*g)*DATA_W   +: DATA_W]),
      .b   (r_s1_win[(3*g+1)*DATA_W +: DATA_W]),
      .c   (r_s1_win[(3*g+2)*DATA_W +: DATA_W]),
      .lo  (w_row_lo[g]),
      .mid (w_row_mid[g]),
      .hi  (w_row_hi[g])
    );
  end

  // Median of nine from row-sorted data: med(max of mins, med of mids, min of maxes).
  assign w_lo_max = max3(r_s2_lo);
  assign w_hi_min = min3(r_s2_hi);

  sort3_u #(.DATA_W(DATA_W)) u_mid_med (
    .a   (r_s2_mid[0]),
    .b   (r_s2_mid[1]),
    .c   (r_s2_mid[2]),
    .lo  (w_unused_mid_lo),
    .mid (w_mid_med),
    .hi  (w_unused_mid_hi)
  );

  sort3_u #(.DATA_W(DATA_W)) u_final_med (
    .a   (w_lo_max),
    .b   (w_mid_med),
    .c   (w_hi_min),
    .lo  (w_unused_med_lo),
    .mid (w_median),
    .hi  (w_unused_med_hi)
  );

  assign w_mean = DATA_W'((r_s2_sum + c_round_add) / c_div);

  always_comb begin
    w_result = r_s2_center;
    case (r_s2_mode)
      MODE_MEAN:   w_result = w_mean;
      MODE_MEDIAN: w_result = w_median;
      default:     w_result = r_s2_center;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_win    <= '0;
      r_s1_mode   <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_mode   <= '0;
      r_s2_sum    <= '0;
      r_s2_lo     <= '0;
      r_s2_mid    <= '0;
      r_s2_hi     <= '0;
      r_s2_center <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_s1_win    <= in_win;
      r_s1_mode   <= in_mode;
      r_s2_valid  <= r_s1_valid;
      r_s2_mode   <= r_s1_mode;
      r_s2_sum    <= w_sum;
      r_s2_lo     <= w_row_lo;
      r_s2_mid    <= w_row_mid;
      r_s2_hi     <= w_row_hi;
      r_s2_center <= r_s1_win[CENTER_IDX*DATA_W +: DATA_W];
      r_out_valid <= r_s2_valid;
      r_out_data  <= w_result;
    end
  end

`ifdef WIN_FILTER_CNT_EN
  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_out_valid && out_ready) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign out_count = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_filter_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for window_filter_pipe: ROUND=0 and ROUND=1 instances
// driven in parallel, scored against a sort/sum reference model.
module tb_window_filter_pipe;

  localparam int DATA_W = 8;
  localparam int W      = 9 * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [W-1:0]      in_win = '0;
  logic [1:0]        in_mode = '0;
  logic              in_ready, in_ready_r;
  logic              out_valid, out_valid_r;
  logic [DATA_W-1:0] out_data, out_data_r;
`ifdef WIN_FILTER_CNT_EN
  logic [31:0]       out_count, out_count_r;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int model_count = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_qr[$];

  always #5 clk = ~clk;

  window_filter_pipe #(.DATA_W(DATA_W), .ROUND(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_win(in_win), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
`ifdef WIN_FILTER_CNT_EN
    , .out_count(out_count)
`endif
  );

  window_filter_pipe #(.DATA_W(DATA_W), .ROUND(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_win(in_win), .in_mode(in_mode), .out_valid(out_valid_r),
    .out_ready(out_ready), .out_data(out_data_r)
`ifdef WIN_FILTER_CNT_EN
    , .out_count(out_count_r)
`endif
  );

  // Delivered-handshake count; the handshake seen at a negedge completes at the next posedge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) model_count = 0;
    else if (out_valid && out_ready) model_count = model_count + 1;
  end

  function automatic logic [DATA_W-1:0] ref_filter(input logic [W-1:0] win,
                                                   input logic [1:0] mode, input int rnd);
    int q[$];
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) begin
      q.push_back(int'(win[i*DATA_W +: DATA_W]));
      s = s + int'(win[i*DATA_W +: DATA_W]);
    end
    q.sort();
    if (mode == 2'b00) return DATA_W'((s + ((rnd != 0) ? 4 : 0)) / 9);
    if (mode == 2'b01) return DATA_W'(q[4]);
    return win[4*DATA_W +: DATA_W];
  endfunction

  function automatic logic [W-1:0] pack9(input int a [9]);
    logic [W-1:0] v;
    for (int i = 0; i < 9; i++) v[i*DATA_W +: DATA_W] = DATA_W'(a[i]);
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    n_tests++;
    if (out_valid !== 1'b0 || out_valid_r !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b/%b expected 0", out_valid, out_valid_r);
    end
    n_tests++;
    if (out_data !== '0 || out_data_r !== '0) begin
      n_fail++; $display("FAIL reset_out_data: got %0d/%0d expected 0", out_data, out_data_r);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
`ifdef WIN_FILTER_CNT_EN
    n_tests++;
    if (out_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", out_count);
    end
`endif
  endtask

  task automatic test_directed();
    int tw [9][9] = '{
      '{1, 2, 3, 4, 5, 6, 7, 8, 9},
      '{255, 255, 255, 255, 255, 255, 255, 255, 255},
      '{0, 0, 0, 0, 8, 0, 0, 0, 0},
      '{4, 4, 4, 4, 8, 4, 4, 4, 4},
      '{9, 1, 8, 2, 7, 3, 6, 4, 5},
      '{7, 7, 7, 0, 0, 0, 255, 255, 255},
      '{200, 200, 200, 200, 200, 0, 0, 0, 0},
      '{9, 1, 8, 2, 7, 3, 6, 4, 5},
      '{9, 1, 8, 2, 7, 3, 6, 4, 5}
    };
    logic [1:0] tm [9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
    int e0 [9] = '{5, 255, 0, 4, 5, 7, 200, 7, 7};
    int e1 [9] = '{5, 255, 1, 4, 5, 7, 200, 7, 7};
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) begin
      in_win = pack9(tw[k]); in_mode = tm[k]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_early: out_valid %b expected 0 one edge after accept", k, out_valid);
      end
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_valid_r !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_latency: out_valid %b/%b expected 1", k, out_valid, out_valid_r);
      end
      n_tests++;
      if (out_data !== DATA_W'(e0[k])) begin
        n_fail++; $display("FAIL dir%0d_floor: got %0d expected %0d", k, out_data, e0[k]);
      end
      n_tests++;
      if (out_data_r !== DATA_W'(e1[k])) begin
        n_fail++; $display("FAIL dir%0d_round: got %0d expected %0d", k, out_data_r, e1[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_stream();
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    prev_stall = 1'b0; prev_data = '0;
    exp_q.delete(); exp_qr.delete();
    for (int cyc = 0; cyc < 460; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 400) begin
        in_valid = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 9; i++)
          in_win[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, (cyc % 3 == 0) ? 3 : 255));
        in_mode = 2'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      @(negedge clk);
      n_tests++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
      end
      if (prev_stall) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_fail++; $display("FAIL rnd_stall_hold: got v=%b d=%0d expected v=1 d=%0d", out_valid, out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra: unexpected output %0d, expected none", out_data);
        end else begin
          logic [DATA_W-1:0] e, er;
          e = exp_q.pop_front(); er = exp_qr.pop_front();
          if (out_data !== e || out_data_r !== er || out_valid_r !== 1'b1) begin
            n_fail++; $display("FAIL rnd_data: got %0d/%0d expected %0d/%0d", out_data, out_data_r, e, er);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_filter(in_win, in_mode, 0));
        exp_qr.push_back(ref_filter(in_win, in_mode, 1));
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_drain: %0d results missing, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

`ifdef WIN_FILTER_CNT_EN
  task automatic test_count();
    n_tests++;
    if (out_count !== 32'(model_count) || out_count_r !== 32'(model_count)) begin
      n_fail++; $display("FAIL count: got %0d/%0d expected %0d", out_count, out_count_r, model_count);
    end
  endtask
`endif

  task automatic test_backpressure();
    logic [W-1:0] bw [6];
    logic [1:0]   bm [6] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11};
    int sent, got, pushed, stall;
    logic saw_full, prev_stall;
    logic [DATA_W-1:0] prev_data;
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 9; i++) bw[k][i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
    sent = 0; got = 0; pushed = 0; stall = 0; saw_full = 1'b0; prev_stall = 1'b0; prev_data = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(posedge clk); #1;
      in_valid = (sent < 6);
      if (sent < 6) begin in_win = bw[sent]; in_mode = bm[sent]; end
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      @(negedge clk);
      n_tests++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++; $display("FAIL bp_in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
      end
      if (out_valid && !out_ready && (pushed - got) == 3 && !in_ready) saw_full = 1'b1;
      if (prev_stall) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_fail++; $display("FAIL bp_stable: got v=%b d=%0d expected v=1 d=%0d", out_valid, out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra: unexpected output %0d", out_data);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++; $display("FAIL bp_data%0d: got %0d expected %0d", got, out_data, e);
          end
        end
        got++;
        if (got == 1) stall = 5;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_filter(in_win, in_mode, 0));
        sent++; pushed++;
      end
    end
    n_tests++;
    if (got != 6) begin
      n_fail++; $display("FAIL bp_count: got %0d results expected 6", got);
    end
    n_tests++;
    if (saw_full !== 1'b1) begin
      n_fail++; $display("FAIL bp_full: in_ready low with 3 held seen=%b expected 1", saw_full);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    int wa [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int wb [9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_win = pack9(wa); in_mode = 2'b00;
    @(posedge clk); #1;
    in_win = pack9(wb); in_mode = 2'b01;
    @(posedge clk); #1;
    in_mode = 2'b10;
    @(posedge clk); #2;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'd5) begin
      n_fail++; $display("FAIL mid_pre: got v=%b d=%0d expected v=1 d=5", out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_valid_r !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_valid: got %b/%b expected 0", out_valid, out_valid_r);
    end
    n_tests++;
    if (out_data !== '0 || out_data_r !== '0) begin
      n_fail++; $display("FAIL mid_async_data: got %0d/%0d expected 0", out_data, out_data_r);
    end
`ifdef WIN_FILTER_CNT_EN
    n_tests++;
    if (out_count !== 32'd0) begin
      n_fail++; $display("FAIL mid_count_reset: got %0d expected 0", out_count);
    end
`endif
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_flushed: out_valid %b expected 0", out_valid);
    end
    in_valid = 1'b1; in_win = pack9(wb); in_mode = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_early: out_valid %b expected 0", out_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'd5) begin
      n_fail++; $display("FAIL mid_latency: got v=%b d=%0d expected v=1 d=5", out_valid, out_data);
    end
    @(posedge clk); #1;
`ifdef WIN_FILTER_CNT_EN
    n_tests++;
    if (out_count !== 32'd1) begin
      n_fail++; $display("FAIL mid_count: got %0d expected 1", out_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_stream();
`ifdef WIN_FILTER_CNT_EN
    test_count();
`endif
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
